// File: rtl/chirp_window_pkg.sv
// chirp_window_pkg: shared widths and constants for the chirp window block.
package chirp_window_pkg;
  localparam int DEF_TDATA_WIDTH     = 32;
  localparam int DEF_INDEX_WIDTH     = 16;
  localparam int DEF_COEF_WIDTH      = 16;
  localparam int DEF_COEF_ADDR_WIDTH = 12;
  localparam int ROUND_HALF          = 1 << (DEF_COEF_WIDTH - 1);
  localparam int COEF_ONE            = (1 << DEF_COEF_WIDTH) - 1;
  localparam int PIPE_DEPTH          = 3;
endpackage

// File: rtl/chirp_window_coef_ram.sv
// chirp_window_coef_ram: read-first simple dual-port coefficient table, powers up as a rectangular window.
module chirp_window_coef_ram
  import chirp_window_pkg::*;
#(
  parameter int AW = DEF_COEF_ADDR_WIDTH,
  parameter int DW = DEF_COEF_WIDTH
) (
  input  logic          aclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW] = '{default: '1};
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axis_chirp_window.sv
// axis_chirp_window: applies a RAM-held window to framed I/Q beats in a 3-stage pipeline.
// Optional CHIRP_WINDOW_BYPASS_EN adds cfg_bypass to pass samples through unmodified.
module axis_chirp_window
  import chirp_window_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int INDEX_WIDTH      = DEF_INDEX_WIDTH,
  parameter int COEF_WIDTH       = DEF_COEF_WIDTH,
  parameter int COEF_ADDR_WIDTH  = DEF_COEF_ADDR_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [3:0]                  cfg_nfft,
`ifdef CHIRP_WINDOW_BYPASS_EN
  input  logic                        cfg_bypass,
`endif
  input  logic                        coef_wr_en,
  input  logic [COEF_ADDR_WIDTH-1:0]  coef_wr_addr,
  input  logic [COEF_WIDTH-1:0]       coef_wr_data,
  output logic                        err_nfft,
  output logic                        err_seq,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [INDEX_WIDTH-1:0]      s_axis_tuser,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [INDEX_WIDTH-1:0]      m_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);
  localparam int CW = AXIS_TDATA_WIDTH / 2;
  localparam int PW = CW + COEF_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (COEF_WIDTH - 1);
  logic adv, acc, nfft_bad, v1, v2, l1, l2;
  logic [3:0] sh;
  logic [COEF_ADDR_WIDTH-1:0] addr;
  logic [COEF_WIDTH-1:0] coef;
  logic [INDEX_WIDTH-1:0] u1, u2, exp_idx;
  logic [AXIS_TDATA_WIDTH-1:0] d1, win, y;
  logic signed [PW-1:0] p_i, p_q, r_i, r_q;
  assign adv = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = adv;
  assign acc = s_axis_tvalid & adv;
  assign nfft_bad = cfg_nfft > 4'(COEF_ADDR_WIDTH);
  assign sh = 4'(COEF_ADDR_WIDTH) - cfg_nfft;
  // shifting the index up lets one full-length table serve every smaller nfft
  assign addr = nfft_bad ? s_axis_tuser[COEF_ADDR_WIDTH-1:0]
                         : COEF_ADDR_WIDTH'(s_axis_tuser << sh);
  assign r_i = p_i + RND;
  assign r_q = p_q + RND;
  assign win = {r_q[COEF_WIDTH +: CW], r_i[COEF_WIDTH +: CW]};
  chirp_window_coef_ram #(.AW(COEF_ADDR_WIDTH), .DW(COEF_WIDTH)) u_ram (
    .aclk    (aclk),
    .wr_en   (coef_wr_en),
    .wr_addr (coef_wr_addr),
    .wr_data (coef_wr_data),
    .rd_en   (acc),
    .rd_addr (addr),
    .rd_data (coef)
  );
`ifdef CHIRP_WINDOW_BYPASS_EN
  logic b1, b2;
  logic [AXIS_TDATA_WIDTH-1:0] d2;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b1 <= 1'b0;
      b2 <= 1'b0;
      d2 <= '0;
    end else if (adv) begin
      if (acc) b1 <= cfg_bypass;
      b2 <= b1;
      d2 <= d1;
    end
  end
  assign y = b2 ? d2 : win;
`else
  assign y = win;
`endif
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      {v1, v2, m_axis_tvalid, l1, l2, m_axis_tlast} <= '0;
      {u1, u2, m_axis_tuser, exp_idx} <= '0;
      {d1, m_axis_tdata} <= '0;
      {p_i, p_q} <= '0;
      {err_nfft, err_seq} <= '0;
    end else begin
      err_nfft <= nfft_bad;
      if (acc) begin
        err_seq <= err_seq | (s_axis_tuser != exp_idx);
        exp_idx <= s_axis_tlast ? '0 : s_axis_tuser + INDEX_WIDTH'(1);
      end
      if (adv) begin
        v1 <= s_axis_tvalid;
        v2 <= v1;
        m_axis_tvalid <= v2;
        if (acc) begin
          d1 <= s_axis_tdata;
          u1 <= s_axis_tuser;
          l1 <= s_axis_tlast;
        end
        u2 <= u1;
        l2 <= l1;
        p_i <= PW'($signed(d1[CW-1:0])) * PW'($signed({1'b0, coef}));
        p_q <= PW'($signed(d1[2*CW-1:CW])) * PW'($signed({1'b0, coef}));
        m_axis_tuser <= u2;
        m_axis_tlast <= l2;
        m_axis_tdata <= y;
      end
    end
  end
endmodule

// File: doc/axis_chirp_window.md
Name: axis_chirp_window

Overview:
- Sits between axis_chirp_framer and the Xilinx FFT core.
- Multiplies each framed I/Q sample by a window coefficient. The coefficient is looked up from the framer's per-beat index on s_axis_tuser.
- Coefficients live in a runtime-writable RAM. One table of 2^COEF_ADDR_WIDTH entries serves every transform size up to that length.
- Passes tlast and tuser through, aligned with the data.

Parameters:
- AXIS_TDATA_WIDTH, 32, packed {Q[31:16], I[15:0]}, both signed two's complement.
- INDEX_WIDTH, 16, width of tuser index.
- COEF_WIDTH, 16, unsigned coefficient, Q0.COEF_WIDTH (65535 ≈ 1.0).
- COEF_ADDR_WIDTH, 12, log2 of table length (max nfft 4096).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- cfg_nfft  in  4  transform size = 1<<cfg_nfft; must equal the framer's setting.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  COEF_ADDR_WIDTH  write address.
- coef_wr_data  in  COEF_WIDTH  write data.
- err_nfft  out  1  registered; high while cfg_nfft > COEF_ADDR_WIDTH.
- err_seq  out  1  sticky index-sequence error.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  framed samples.
- s_axis_tuser  in  INDEX_WIDTH  sample index within frame.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tlast  in  1  slave last.
- s_axis_tready  out  1  slave ready.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  windowed samples.
- m_axis_tuser  out  INDEX_WIDTH  index, passed through.
- m_axis_tvalid  out  1  master valid.
- m_axis_tlast  out  1  master last.
- m_axis_tready  in  1  master ready.

Behaviour:
- Reset state:
  - All pipeline valid bits 0.
  - m_axis_tvalid, m_axis_tlast, err_nfft, err_seq = 0; m_axis_tdata, m_axis_tuser = 0.
  - Coefficient RAM is not reset. Its power-up contents are all 65535 (rectangular window).
- Pipeline: 3 stages, all advancing on a single signal adv = ~v3 | m_axis_tready.
  - S1: RAM read.
  - S2: signed multiply, I and Q.
  - S3: round and output register.
  - s_axis_tready = adv (combinational from m_axis_tready).
  - Beat accepted when s_axis_tvalid & adv.
  - Latency 3 cycles from acceptance to m_axis_tvalid with no backpressure. Full throughput of 1 beat/cycle.
- Handshake rules:
  - While stalled (v3 & ~m_axis_tready), all stage registers hold.
  - Bubbles propagate as valid=0.
  - m_axis_tdata, m_axis_tuser, m_axis_tlast are stable while m_axis_tvalid & ~m_axis_tready.
- Address: addr = (tuser << (COEF_ADDR_WIDTH − cfg_nfft)) truncated to COEF_ADDR_WIDTH. A single table therefore decimates cleanly for smaller nfft.
- Invalid cfg_nfft: if cfg_nfft > COEF_ADDR_WIDTH, err_nfft=1 and addr = tuser[COEF_ADDR_WIDTH-1:0]. Data still flows.
- Arithmetic, per component:
  - p = x × {1'b0, coef}, 33-bit signed.
  - y = (p + 2^(COEF_WIDTH−1)) >>> COEF_WIDTH, taking the low 16 bits. Round half up.
  - No saturation needed: |coef| < 1 guarantees |y| ≤ 32767 for x = −32768.
- RAM write:
  - Writes are synchronous; permitted at any time, including while streaming.
  - Same-cycle write and read to the same address returns the old value (read-first).
  - Reads occur only when adv & s_axis_tvalid, so a stall does not change S1 data.
- err_seq:
  - Expected index = 0 after reset, and after any accepted beat with tlast.
  - Otherwise expected index = previous accepted index + 1.
  - An accepted beat with a mismatched tuser sets err_seq. It clears only on reset.
  - The expected index resynchronises to the received value + 1.
- Reset asserted mid-frame flushes the pipeline and clears the expected index to 0.

Optional Feature:
- Macro CHIRP_WINDOW_BYPASS_EN adds input cfg_bypass (1 bit).
- With the macro: when cfg_bypass=1, m_axis_tdata equals the accepted s_axis_tdata exactly, with identical 3-cycle latency and handshake. cfg_bypass is sampled per beat at S1 acceptance, so toggling mid-frame affects only later beats.
- Without the macro: there is no cfg_bypass port and no bypass mux.

Decomposition:
- Package chirp_window_pkg:
  - Default widths.
  - Constant ROUND_HALF = 1<<(COEF_WIDTH−1).
  - Constant COEF_ONE = 2^COEF_WIDTH−1.
  - Pipeline depth constant = 3.
- One sub-module, chirp_window_coef_ram: simple dual-port, one write port plus one read port with read-enable, read-first, initialised to COEF_ONE.

Test Plan:
- Rectangular default, nfft=4, 16 beats with I=1000, Q=−1000 → output I=1000, Q=−1000 (1000×65535/65536 rounds to 1000); tlast on tuser=15; latency 3 cycles.
- Write coef[0x800]=32768, nfft=4, beat tuser=8 with I=−32768, Q=32767 → I=−16384, Q=16384 (16383.5 rounded up).
- Backpressure: m_axis_tready random 50%, 64 beats → output order, tuser and tlast match input exactly; no beat lost or duplicated; outputs stable while stalled.
- Sequence error: feed tuser 0,1,3 → err_seq rises one cycle after tuser=3 is accepted and stays high until aresetn low.
- cfg_nfft=13 → err_nfft=1 within 1 cycle; data continues to flow. cfg_nfft back to 12 → err_nfft=0.
- With CHIRP_WINDOW_BYPASS_EN, cfg_bypass=1, coef table all 0 → output equals input bit-exact.
